fetch_align: RTL and testbench
==============================

# fetch_align

Fetch-side instruction aligner for the RV32IMC core, sitting between the instruction-fetch port and the decode stage. It accepts 32-bit words from the fetch unit and buffers them as halfwords. It delivers one whole instruction per cycle to decode: either a 16-bit compressed one, zero-extended, or a 32-bit one, including one that straddles two fetch words. Each instruction carries its PC and its fetch-fault status. Redirects (branch/jump/trap) flush the buffer and re-seed the PC.

## Interface
Parameters:
- XLEN, 32, data/PC width
- RESET_VECTOR, 32'h8000_0000, instruction PC after reset
- BUF_HW, 4, halfword buffer depth (fixed at 4; other values unsupported)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  redirect; drop buffered halfwords
- flush_pc_i  in  XLEN  new PC on flush (bit 0 ignored)
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  aligner can accept a word
- fetch_data_i  in  32  fetch word; [15:0] = lower halfword
- fetch_fault_i  in  1  access fault on this word
- inst_valid_o  out  1  complete instruction available
- inst_ready_i  in  1  decode accepts instruction
- inst_o  out  32  raw instruction; [31:16]=0 when compressed
- inst_pc_o  out  XLEN  PC of inst_o
- inst_compressed_o  out  1  inst_o is 16-bit
- inst_fault_o  out  1  any halfword of inst_o faulted

## Operation
- State: 4-entry halfword FIFO (16-bit data plus fault bit each), count 0..4, head PC register, skip_lo flag.
- Push: a word is accepted when fetch_valid_i && fetch_ready_o.
  - Both halfwords are pushed, lower first.
  - If skip_lo=1, only the upper halfword is pushed and skip_lo clears.
  - fetch_fault_i is copied to each pushed entry.
- fetch_ready_o = !flush_i && (count <= 2).
- Head decode: compressed iff head[1:0] != 2'b11.
- inst_valid_o is asserted when any of the following holds:
  - count >= 1 and the head is compressed;
  - count >= 2;
  - count >= 1 and the head entry faulted. This is a faulted 32-bit head; it issues alone with inst_fault_o=1 and inst_compressed_o=0.
- Pop on inst_valid_o && inst_ready_i.
  - 1 halfword if compressed or a lone faulted head, otherwise 2.
  - head PC advances by 2 or 4, respectively; modulo 2^XLEN, wrap allowed.
- Simultaneous push and pop in the same cycle is legal. Next count = count + pushed − popped; it never exceeds 4 by construction.
- Flush has priority over everything in the same cycle:
  - count ← 0, head PC ← {flush_pc_i[XLEN-1:1],1'b0}, skip_lo ← flush_pc_i[1];
  - any push or pop in that cycle is discarded.
- When inst_valid_o=0, inst_o, inst_compressed_o and inst_fault_o are driven 0; inst_pc_o always shows the head PC.
- The fetch unit supplies words in sequential order starting at the word containing the head PC. The aligner does not check the word PC.

## Timing
- Reset values: count=0, head PC=RESET_VECTOR, skip_lo=0.
  - Outputs: inst_valid_o=0, inst_o=0, inst_compressed_o=0, inst_fault_o=0, fetch_ready_o=1, inst_pc_o=RESET_VECTOR.
- Latency: a word accepted at edge N gives inst_valid_o high in the cycle after edge N, for a complete head instruction. Outputs are combinational from registered state; no input-to-output combinational path except fetch_ready_o from flush_i.
- Straddling 32-bit instruction: valid only after the word carrying its upper half has been accepted.
- Throughput: one instruction per cycle sustained for any mix of 16/32-bit code with continuous fetch.
- Reset asserted mid-operation: next cycle equals the reset state regardless of flush or handshake inputs.
- Full (count=4, or count=3): fetch_ready_o=0, and a pop in that cycle does not re-enable it until the next cycle.
- Empty: inst_valid_o=0.

## Structure
- Add to tcore_param: constant RESET_VECTOR and typedef fetch_hw_t (struct: data[15:0], fault). The is_compressed(halfword) function goes in the shared package; decode's control unit uses it too.
- One sub-module is natural: halfword_fifo. It is a 4-entry FIFO with 0/1/2 push and 0/1/2 pop per cycle, plus a flush. The aligner's own logic is the issue decision, pop count, PC and skip_lo.

## Test plan
- Reset then one word 32'h0051_0113 (addi, 32-bit) at 0x8000_0000 → next cycle inst_valid_o=1, inst_o=32'h0051_0113, inst_pc_o=0x8000_0000, inst_compressed_o=0.
- Word 32'h4501_4081 (two compressed) → two consecutive instructions 32'h0000_4081 @0x8000_0000 and 32'h0000_4501 @0x8000_0002, both compressed.
- Straddle: word {16'h0113, 16'h4081}, then {16'h4505, 16'h0051}, with decode always ready:
  - cycle N+1: 0x4081 @0x8000_0000;
  - cycle N+2: 0x0051_0113 @0x8000_0002;
  - cycle N+3: 0x0000_4505 @0x8000_0006.
- Flush to 0x8000_0102, then word {16'h4505, 16'hFFFF} → lower ignored; first instruction 0x0000_4505 @0x8000_0102.
- Fault: 32-bit head whose second word has fetch_fault_i=1 → one instruction with inst_fault_o=1, PC advance 4. A single faulted word → inst_fault_o=1 for the head instruction.
- Backpressure: inst_ready_i=0 while 3 words are offered → fetch_ready_o drops at count 3; no halfword lost or duplicated when inst_ready_i resumes. Flush and push in the same cycle → count=0.

Source files
------------

// File: rtl/fetch_align_pkg.sv
// Types and helpers shared by the fetch aligner and the decode control unit.
// Holds the default reset PC, the halfword buffer entry and RVC length decode.
package fetch_align_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;

    typedef struct packed {
        logic [15:0] data;
        logic        fault;
    } fetch_hw_t;

    // Any low two bits other than 2'b11 mark a 16-bit RVC encoding.
    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_halfword_fifo.sv
// Four-entry halfword FIFO with 0/1/2 pushes and 0/1/2 pops per cycle plus flush.
// The two oldest entries are always visible so a straddling instruction reads in one cycle.
module halfword_fifo
    import fetch_align_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic [1:0] push_cnt_i,
    input  fetch_hw_t  push0_i,
    input  fetch_hw_t  push1_i,
    input  logic [1:0] pop_cnt_i,
    output fetch_hw_t  head_o,
    output fetch_hw_t  next_o,
    output logic [2:0] count_o
);

    fetch_hw_t  mem_q [4];
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] wr_ptr;
    logic [2:0] count_q, count_d;

    assign wr_ptr = rd_ptr_q + count_q[1:0];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        rd_ptr_d = rd_ptr_q + pop_cnt_i;
        count_d  = count_q + {1'b0, push_cnt_i} - {1'b0, pop_cnt_i};
        if (flush_i) begin
            rd_ptr_d = 2'd0;
            count_d  = 3'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; entries outside [head, head+count) are never observed.
    always_ff @(posedge clk_i) begin
        if (!flush_i && push_cnt_i != 2'd0) mem_q[wr_ptr]        <= push0_i;
        if (!flush_i && push_cnt_i == 2'd2) mem_q[wr_ptr + 2'd1] <= push1_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_q + 2'd1];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_align.sv
// Instruction aligner: buffers fetch words as halfwords and issues one whole
// RV32IMC instruction per cycle with its PC and fault status.
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = fetch_align_pkg::RESET_VECTOR,
    parameter int unsigned     BUF_HW       = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [31:0]     fetch_data_i,
    input  logic            fetch_fault_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_compressed_o,
    output logic            inst_fault_o
);

    fetch_hw_t       head_hw, next_hw, push0, push1;
    logic [2:0]      count;
    logic [1:0]      push_cnt, pop_cnt;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            skip_lo_q, skip_lo_d;
    logic            head_c, lone_fault, pop_two, accept, fire;

    halfword_fifo u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .push_cnt_i (push_cnt),
        .push0_i    (push0),
        .push1_i    (push1),
        .pop_cnt_i  (pop_cnt),
        .head_o     (head_hw),
        .next_o     (next_hw),
        .count_o    (count)
    );

    // Room for a full word is judged on registered occupancy, so a pop never re-opens it early.
    assign fetch_ready_o = !flush_i && (count <= 3'(BUF_HW - 2));
    assign accept        = fetch_valid_i && fetch_ready_o;

    always_comb begin
        push_cnt   = accept ? (skip_lo_q ? 2'd1 : 2'd2) : 2'd0;
        push0.data = skip_lo_q ? fetch_data_i[31:16] : fetch_data_i[15:0];
        push0.fault = fetch_fault_i;
        push1.data  = fetch_data_i[31:16];
        push1.fault = fetch_fault_i;
    end

    always_comb begin
        head_c            = is_compressed(head_hw.data);
        lone_fault        = (count == 3'd1) && head_hw.fault && !head_c;
        inst_valid_o      = (count != 3'd0) && (head_c || count >= 3'd2 || head_hw.fault);
        pop_two           = !head_c && !lone_fault;
        inst_o            = 32'd0;
        inst_compressed_o = 1'b0;
        inst_fault_o      = 1'b0;
        if (inst_valid_o) begin
            if (head_c) begin
                inst_o            = {16'd0, head_hw.data};
                inst_compressed_o = 1'b1;
                inst_fault_o      = head_hw.fault;
            end else if (lone_fault) begin
                inst_o       = {16'd0, head_hw.data};
                inst_fault_o = 1'b1;
            end else begin
                inst_o       = {next_hw.data, head_hw.data};
                inst_fault_o = head_hw.fault || next_hw.fault;
            end
        end
    end

    assign fire    = inst_valid_o && inst_ready_i && !flush_i;
    assign pop_cnt = fire ? (pop_two ? 2'd2 : 2'd1) : 2'd0;

    always_comb begin
        pc_d      = pc_q;
        skip_lo_d = skip_lo_q;
        if (flush_i) begin
            pc_d      = flush_pc_i & {{(XLEN-1){1'b1}}, 1'b0};
            skip_lo_d = flush_pc_i[1];
        end else begin
            if (fire)   pc_d      = pc_q + (pop_two ? XLEN'(4) : XLEN'(2));
            if (accept) skip_lo_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= RESET_VECTOR;
            skip_lo_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            skip_lo_q <= skip_lo_d;
        end
    end

    assign inst_pc_o = pc_q;

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: hand-derived cycle table for the corner cases, then
// randomized traffic compared against a halfword-queue reference model.
module tb_fetch_align;
    import fetch_align_pkg::*;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, fetch_valid_i, fetch_ready_o, fetch_fault_i;
    logic        inst_valid_o, inst_ready_i, inst_compressed_o, inst_fault_o;
    logic [31:0] flush_pc_i, fetch_data_i, inst_o, inst_pc_o;

    always #5 clk_i = ~clk_i;

    fetch_align dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .flush_pc_i        (flush_pc_i),
        .fetch_valid_i     (fetch_valid_i),
        .fetch_ready_o     (fetch_ready_o),
        .fetch_data_i      (fetch_data_i),
        .fetch_fault_i     (fetch_fault_i),
        .inst_valid_o      (inst_valid_o),
        .inst_ready_i      (inst_ready_i),
        .inst_o            (inst_o),
        .inst_pc_o         (inst_pc_o),
        .inst_compressed_o (inst_compressed_o),
        .inst_fault_o      (inst_fault_o)
    );

    typedef struct packed {
        logic        valid, ready, comp, fault;
        logic [31:0] inst, pc;
    } obs_t;

    typedef struct {
        logic        rst, flush;
        logic [31:0] fpc;
        logic        fv;
        logic [31:0] fd;
        logic        ff, ir;
        obs_t        exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: program-order halfword queue, head PC and the skip flag.
    fetch_hw_t   mq[$];
    logic [31:0] m_pc   = RV;
    logic        m_skip = 1'b0;

    function automatic obs_t model_obs(input logic flush, output int len);
        obs_t o;
        int   n;
        n       = mq.size();
        o       = '0;
        len     = 0;
        o.pc    = m_pc;
        o.ready = !flush && n <= 2;
        if (n > 0) begin
            if (mq[0].data[1:0] != 2'b11) begin
                o.valid = 1'b1; o.comp = 1'b1; o.fault = mq[0].fault;
                o.inst  = {16'h0, mq[0].data}; len = 1;
            end else if (n >= 2) begin
                o.valid = 1'b1; o.fault = mq[0].fault | mq[1].fault;
                o.inst  = {mq[1].data, mq[0].data}; len = 2;
            end else if (mq[0].fault) begin
                o.valid = 1'b1; o.fault = 1'b1;
                o.inst  = {16'h0, mq[0].data}; len = 1;
            end
        end
        return o;
    endfunction

    function automatic void model_update(input vec_t v, input obs_t e, input int len);
        fetch_hw_t hw;
        if (v.rst) begin
            mq.delete(); m_pc = RV; m_skip = 1'b0;
        end else if (v.flush) begin
            mq.delete(); m_pc = {v.fpc[31:1], 1'b0}; m_skip = v.fpc[1];
        end else begin
            if (e.valid && v.ir) begin
                repeat (len) void'(mq.pop_front());
                m_pc = m_pc + 32'(2 * len);
            end
            if (v.fv && e.ready) begin
                if (!m_skip) begin
                    hw.data = v.fd[15:0]; hw.fault = v.ff; mq.push_back(hw);
                end
                hw.data = v.fd[31:16]; hw.fault = v.ff; mq.push_back(hw);
                m_skip = 1'b0;
            end
        end
    endfunction

    task automatic check(input string nm, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got v=%0b r=%0b c=%0b f=%0b inst=%08h pc=%08h, expected v=%0b r=%0b c=%0b f=%0b inst=%08h pc=%08h",
                     nm, act.valid, act.ready, act.comp, act.fault, act.inst, act.pc,
                     exp.valid, exp.ready, exp.comp, exp.fault, exp.inst, exp.pc);
        end
    endtask

    // mode 0: drive only, 1: compare with the vector's expectation, 2: compare with the model
    task automatic step(input vec_t v, input int mode, input string nm);
        obs_t act, mexp;
        int   len;
        rst_i = v.rst; flush_i = v.flush; flush_pc_i = v.fpc;
        fetch_valid_i = v.fv; fetch_data_i = v.fd; fetch_fault_i = v.ff; inst_ready_i = v.ir;
        #1;
        act  = {inst_valid_o, fetch_ready_o, inst_compressed_o, inst_fault_o, inst_o, inst_pc_o};
        mexp = model_obs(v.flush, len);
        if (mode == 1)      check(nm, act, v.exp);
        else if (mode == 2) check(nm, act, mexp);
        @(posedge clk_i);
        model_update(v, mexp, len);
        @(negedge clk_i);
    endtask

    function automatic vec_t mk(input logic rst, flush, input logic [31:0] fpc, input logic fv,
                                input logic [31:0] fd, input logic ff, ir, ev,
                                input logic [31:0] ei, epc, input logic ec, ef, er);
        vec_t v;
        v.rst = rst; v.flush = flush; v.fpc = fpc; v.fv = fv; v.fd = fd; v.ff = ff; v.ir = ir;
        v.exp.valid = ev; v.exp.ready = er; v.exp.comp = ec; v.exp.fault = ef;
        v.exp.inst = ei; v.exp.pc = epc;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        vec_t r;
        //             rst flush fpc           fv fd            ff ir  ev ei            epc           ec ef er
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  0, 32'h0,         32'h8000_0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0051_0113, 0, 1,  0, 32'h0,         32'h8000_0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  1, 32'h0051_0113, 32'h8000_0000, 0, 0, 1));
        tbl.push_back(mk(1, 0, 32'h0,          0, 32'h0,         0, 1,  0, 32'h0,         32'h8000_0004, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h4501_4081, 0, 1,  0, 32'h0,         32'h8000_0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  1, 32'h0000_4081, 32'h8000_0000, 1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  1, 32'h0000_4501, 32'h8000_0002, 1, 0, 1));
        tbl.push_back(mk(1, 0, 32'h0,          0, 32'h0,         0, 1,  0, 32'h0,         32'h8000_0004, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0113_4081, 0, 1,  0, 32'h0,         32'h8000_0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h4505_0051, 0, 1,  1, 32'h0000_4081, 32'h8000_0000, 1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  1, 32'h0051_0113, 32'h8000_0002, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  1, 32'h0000_4505, 32'h8000_0006, 1, 0, 1));
        tbl.push_back(mk(0, 1, 32'h8000_0102,  1, 32'hdead_beef, 0, 1,  0, 32'h0,         32'h8000_0008, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h4505_ffff, 0, 1,  0, 32'h0,         32'h8000_0102, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  1, 32'h0000_4505, 32'h8000_0102, 1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0113_4081, 0, 1,  0, 32'h0,         32'h8000_0104, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h4505_0051, 1, 1,  1, 32'h0000_4081, 32'h8000_0104, 1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  1, 32'h0051_0113, 32'h8000_0106, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  1, 32'h0000_4505, 32'h8000_010a, 1, 1, 1));
        tbl.push_back(mk(0, 1, 32'h8000_0202,  0, 32'h0,         0, 1,  0, 32'h0,         32'h8000_010c, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0013_ffff, 1, 1,  0, 32'h0,         32'h8000_0202, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  1, 32'h0000_0013, 32'h8000_0202, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  0, 32'h0,         32'h8000_0204, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0051_0113, 0, 0,  0, 32'h0,         32'h8000_0204, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0021_0093, 0, 0,  1, 32'h0051_0113, 32'h8000_0204, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0031_0193, 0, 0,  1, 32'h0051_0113, 32'h8000_0204, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0031_0193, 0, 1,  1, 32'h0051_0113, 32'h8000_0204, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0031_0193, 0, 1,  1, 32'h0021_0093, 32'h8000_0208, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  1, 32'h0031_0193, 32'h8000_020c, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0051_0113, 0, 1,  0, 32'h0,         32'h8000_0210, 0, 0, 1));
        tbl.push_back(mk(0, 1, 32'h8000_0400,  1, 32'h0021_0093, 0, 1,  1, 32'h0051_0113, 32'h8000_0210, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  0, 32'h0,         32'h8000_0400, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h4501_4081, 0, 1,  0, 32'h0,         32'h8000_0400, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'h0,          1, 32'h0021_0093, 0, 1,  1, 32'h0000_4081, 32'h8000_0400, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  0, 32'h0,         32'h8000_0000, 0, 0, 1));
        tbl.push_back(mk(0, 1, 32'hffff_fffe,  0, 32'h0,         0, 1,  0, 32'h0,         32'h8000_0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 32'h4081_0000, 0, 1,  0, 32'h0,         32'hffff_fffe, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  1, 32'h0000_4081, 32'hffff_fffe, 1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,         0, 1,  0, 32'h0,         32'h0000_0000, 0, 0, 1));

        rst_i = 1'b1; flush_i = 1'b0; flush_pc_i = '0; fetch_valid_i = 1'b0;
        fetch_data_i = '0; fetch_fault_i = 1'b0; inst_ready_i = 1'b0;
        @(negedge clk_i);
        r = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(r, 0, "reset");
        step(r, 0, "reset");

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], 1, $sformatf("vec%0d", i));

        for (int i = 0; i < 3000; i++) begin
            r = mk(($urandom_range(199) == 0), ($urandom_range(24) == 0), $urandom,
                   ($urandom_range(3) != 0), $urandom, ($urandom_range(15) == 0),
                   ($urandom_range(3) != 0), 0, 0, 0, 0, 0, 0);
            step(r, 2, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
